rf_wb_sequencer: RTL and testbench
==================================

Name: rf_wb_sequencer

Overview:
Sequences writebacks from the two superscalar execution lanes onto the single register-file write port (WE3/WA3/WD3).
- Holds results in an in-order queue and retires one write per cycle in program order (lane0 older than lane1).
- Exports a per-register pending mask so issue logic can stall on in-flight writes.
- Exports a forwarding lookup so operand reads see the youngest queued value.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
XLEN, 32, data width
AW, 5, register address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
wb0_valid  in  1  lane0 (older) writeback request
wb0_addr  in  AW  lane0 destination register
wb0_data  in  XLEN  lane0 result
wb1_valid  in  1  lane1 (younger) writeback request
wb1_addr  in  AW  lane1 destination register
wb1_data  in  XLEN  lane1 result
wb_ready  out  1  both lanes may present this cycle
rf_we  out  1  to register file WE3
rf_wa  out  AW  to register file WA3
rf_wd  out  XLEN  to register file WD3
pending  out  2**AW  bit r set = write to r queued
lk_addr  in  AW  forwarding lookup address
lk_hit  out  1  queued entry matches lk_addr
lk_data  out  XLEN  data of youngest matching entry
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, rst_n=0):
  - Pointers and count are 0; all entries are invalid.
  - rf_we=0, rf_wa=0, rf_wd=0, pending=0, lk_hit=0, lk_data=0.
  - Outputs take these values immediately, not at the next edge.
  - wb_ready=1 during reset (count=0), but no enqueue occurs while rst_n=0.
  - Reset mid-operation discards all queued writes.
- wb_ready = (DEPTH - count) >= 2. It is combinational from registered count and does not depend on wb*_valid.
- Accept:
  - A lane is accepted at a rising edge when wb_ready=1 and wbN_valid=1.
  - If wb_ready=0, the lanes must hold their requests. The block ignores them; no partial acceptance.
- Writes with wbN_addr=0 are dropped at input: not enqueued, no pending bit, no count change.
- Enqueue order is lane0 first, then lane1. If only one lane is valid and non-zero, it takes one slot.
- Drain:
  - rf_we = (count != 0).
  - rf_wa and rf_wd are taken combinationally from the head entry.
  - The head pops at every rising edge where rf_we=1. The register file commits on that same edge.
- Latency: a request accepted at edge N drives rf_we in the cycle after N at the earliest. With an empty queue, it is written at edge N+1.
- Simultaneous events:
  - Enqueue (0, 1 or 2) and dequeue (0 or 1) can happen at the same edge.
  - count_next = count + enq - deq. count never exceeds DEPTH.
- Pointers wrap modulo DEPTH.
- Same destination in both lanes: both entries are enqueued. Lane1 drains last, so its value is final.
- pending[r] = OR over valid entries of (addr == r). pending[0] is always 0. A bit clears only when the last matching entry pops.
- Forwarding lookup (combinational):
  - lk_hit=1 iff some valid entry has addr == lk_addr and lk_addr != 0.
  - lk_data = data of the youngest such entry (closest to tail); 0 when lk_hit=0.
  - The entry popping in the current cycle still counts as valid.

Decomposition:
- Package rf_wb_pkg: XLEN, AW, DEPTH defaults and the entry typedef {addr[AW-1:0], data[XLEN-1:0]}.
- Sub-module rf_wb_fifo: storage, head/tail pointers, count, and 0/1/2-push with 0/1-pop.
- rf_wb_sequencer instantiates rf_wb_fifo and contains the input filter, pending mask and forwarding search.

Test Plan:
- Reset then idle -> rf_we=0, pending=0, count=0, wb_ready=1; drive rst_n=0 with 3 entries queued -> count=0, rf_we=0 immediately.
- Both lanes valid, wb0=(x3, 0x02345432), wb1=(x4, 0xF7421035), empty queue -> rf_we=1 with x3/0x02345432 in the next cycle, then x4/0xF7421035 the cycle after; pending[3], pending[4] set then cleared in order.
- Both lanes target x1 with 0x11111111 (lane0) and 0x22222222 (lane1) -> two writes in order; lk_addr=1 gives lk_hit=1, lk_data=0x22222222 until the final pop; pending[1] stays set until the second write.
- wb0_addr=0, wb1=(x2, 0xABCD) -> only one entry enqueued, count=1, pending[0]=0, single write to x2.
- Both lanes valid with x5..x12 every cycle, DEPTH=4 -> wb_ready drops to 0 when count>=3; no loss or duplication; drained sequence is x5..x12 in order across pointer wrap.
- Enqueue two while one drains at count=2 -> count goes to 3; wb_ready=0 the next cycle, back to 1 after one more pop.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared defaults and queue entry layout for the writeback sequencer.
package rf_wb_pkg;
    localparam int DEF_XLEN  = 32;
    localparam int DEF_AW    = 5;
    localparam int DEF_DEPTH = 4;

    typedef struct packed {
        logic [DEF_AW-1:0]   addr;
        logic [DEF_XLEN-1:0] data;
    } entry_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: circular queue with 0/1/2 pushes and 0/1 pop per cycle.
// Ports: push_i = number of entries to push (d0_i first, then d1_i), pop_i pops the head,
//        mem_o exposes raw storage, head_o the oldest slot, count_o the occupancy.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int  DEPTH = DEF_DEPTH,
    parameter type T     = entry_t,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    push_i,
    input  T              d0_i,
    input  T              d1_i,
    input  logic          pop_i,
    output T              mem_o [DEPTH],
    output logic [PW-1:0] head_o,
    output logic [PW:0]   count_o
);
    T              mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   count_q, count_d;

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    always_comb begin
        head_d  = head_q + PW'(pop_i);
        tail_d  = tail_q + PW'(push_i);
        count_d = count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: only slots inside [head, head+count) are ever observed.
    always_ff @(posedge clk) begin
        if (push_i != 2'd0) mem_q[tail_q] <= d0_i;
        if (push_i == 2'd2) mem_q[tail_q + PW'(1)] <= d1_i;
    end

    assign mem_o   = mem_q;
    assign head_o  = head_q;
    assign count_o = count_q;
endmodule

// File: rtl/rf_wb_sequencer.sv
// rf_wb_sequencer: merges two writeback lanes onto one register-file write port in program order.
// Ports: wb0_*/wb1_* lane requests (lane0 older), wb_ready accept window,
//        rf_we/rf_wa/rf_wd register-file write port, pending in-flight mask,
//        lk_addr/lk_hit/lk_data forwarding lookup, count queue occupancy.
module rf_wb_sequencer
    import rf_wb_pkg::*;
#(
    parameter int  DEPTH = DEF_DEPTH,
    parameter int  XLEN  = DEF_XLEN,
    parameter int  AW    = DEF_AW,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb0_valid,
    input  logic [AW-1:0]     wb0_addr,
    input  logic [XLEN-1:0]   wb0_data,
    input  logic              wb1_valid,
    input  logic [AW-1:0]     wb1_addr,
    input  logic [XLEN-1:0]   wb1_data,
    output logic              wb_ready,
    output logic              rf_we,
    output logic [AW-1:0]     rf_wa,
    output logic [XLEN-1:0]   rf_wd,
    output logic [2**AW-1:0]  pending,
    input  logic [AW-1:0]     lk_addr,
    output logic              lk_hit,
    output logic [XLEN-1:0]   lk_data,
    output logic [PW:0]       count
);
    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t          mem [DEPTH];
    ent_t          e0, e1, d0;
    logic [PW-1:0] head;
    logic          acc0, acc1;
    logic [1:0]    push;

    assign wb_ready = (DEPTH - int'(count)) >= 2;

    // Writes to x0 are discarded before they take a slot.
    assign acc0 = wb_ready && wb0_valid && (wb0_addr != '0);
    assign acc1 = wb_ready && wb1_valid && (wb1_addr != '0);
    assign push = {acc0 && acc1, acc0 ^ acc1};
    assign e0   = '{addr: wb0_addr, data: wb0_data};
    assign e1   = '{addr: wb1_addr, data: wb1_data};
    // A lone lane1 request fills the first push slot so entries stay contiguous.
    assign d0   = acc0 ? e0 : e1;

    rf_wb_fifo #(.DEPTH(DEPTH), .T(ent_t)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .d0_i    (d0),
        .d1_i    (e1),
        .pop_i   (rf_we),
        .mem_o   (mem),
        .head_o  (head),
        .count_o (count)
    );

    assign rf_we = count != '0;
    assign rf_wa = rf_we ? mem[head].addr : '0;
    assign rf_wd = rf_we ? mem[head].data : '0;

    // Walk oldest to youngest so the last match seen is the youngest value.
    always_comb begin
        pending = '0;
        lk_hit  = 1'b0;
        lk_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k < int'(count)) begin
                pending[mem[head + PW'(k)].addr] = 1'b1;
                if (lk_addr != '0 && mem[head + PW'(k)].addr == lk_addr) begin
                    lk_hit  = 1'b1;
                    lk_data = mem[head + PW'(k)].data;
                end
            end
        end
        pending[0] = 1'b0;
    end
endmodule

// File: tb/tb_rf_wb_sequencer.sv
// tb_rf_wb_sequencer: directed and random checks of rf_wb_sequencer against a queue model.
module tb_rf_wb_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb0_valid, wb1_valid, wb_ready, rf_we, lk_hit;
    logic [4:0]  wb0_addr, wb1_addr, rf_wa, lk_addr;
    logic [31:0] wb0_data, wb1_data, rf_wd, lk_data, pending;
    logic [2:0]  count;

    int checks = 0;
    int fails  = 0;
    bit took;

    typedef struct {logic [4:0] a; logic [31:0] d;} ent_t;
    ent_t q[$];
    int   dlog[$];

    always #5 clk = ~clk;

    rf_wb_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
        .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
        .wb_ready(wb_ready), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .pending(pending), .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_data(lk_data),
        .count(count)
    );

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, o, e);
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] ep = '0;
        logic        eh = 1'b0;
        logic [31:0] ed = '0;
        foreach (q[i]) begin
            ep[q[i].a] = 1'b1;
            if (q[i].a == lk_addr && lk_addr != 0) begin
                eh = 1'b1;
                ed = q[i].d;
            end
        end
        chk({tag, "_count"}, count, q.size());
        chk({tag, "_ready"}, wb_ready, (4 - q.size()) >= 2);
        chk({tag, "_we"}, rf_we, q.size() != 0);
        chk({tag, "_wa"}, rf_wa, q.size() != 0 ? q[0].a : 5'd0);
        chk({tag, "_wd"}, rf_wd, q.size() != 0 ? q[0].d : 32'd0);
        chk({tag, "_pending"}, pending, ep);
        chk({tag, "_lk_hit"}, lk_hit, eh);
        chk({tag, "_lk_data"}, lk_data, ed);
    endtask

    // Called at a negedge: drive, check pre-edge state, advance the model across the posedge.
    task automatic cyc(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] la);
        wb0_valid = v0; wb0_addr = a0; wb0_data = d0;
        wb1_valid = v1; wb1_addr = a1; wb1_data = d1;
        lk_addr = la;
        #1;
        check_model("cyc");
        if (rf_we) dlog.push_back(int'(rf_wa));
        took = rst_n && ((4 - q.size()) >= 2);
        @(posedge clk);
        if (rst_n) begin
            if (q.size() != 0) void'(q.pop_front());
            if (took && v0 && a0 != 0) q.push_back('{a0, d0});
            if (took && v1 && a1 != 0) q.push_back('{a1, d1});
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] la);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, la);
    endtask

    initial begin
        int i, n;
        rst_n = 1'b0;
        wb0_valid = 0; wb0_addr = 0; wb0_data = 0;
        wb1_valid = 0; wb1_addr = 0; wb1_data = 0; lk_addr = 0;
        #1;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(5'd0);
        idle(5'd0);
        // Two lanes into an empty queue
        cyc(1, 5'd3, 32'h02345432, 1, 5'd4, 32'hF7421035, 5'd0);
        chk("t2_wa0", rf_wa, 5'd3);
        chk("t2_wd0", rf_wd, 32'h02345432);
        chk("t2_pend0", pending, 32'h18);
        idle(5'd0);
        chk("t2_wa1", rf_wa, 5'd4);
        chk("t2_wd1", rf_wd, 32'hF7421035);
        chk("t2_pend1", pending, 32'h10);
        idle(5'd0);
        chk("t2_we_off", rf_we, 1'b0);
        // Same destination in both lanes
        cyc(1, 5'd1, 32'h11111111, 1, 5'd1, 32'h22222222, 5'd1);
        chk("t3_lk_data0", lk_data, 32'h22222222);
        chk("t3_wd0", rf_wd, 32'h11111111);
        idle(5'd1);
        chk("t3_lk_data1", lk_data, 32'h22222222);
        chk("t3_pend1", pending[1], 1'b1);
        idle(5'd1);
        chk("t3_lk_hit_off", lk_hit, 1'b0);
        chk("t3_pend_off", pending[1], 1'b0);
        // Lane0 targets x0
        cyc(1, 5'd0, 32'hDEADBEEF, 1, 5'd2, 32'h0000ABCD, 5'd0);
        chk("t4_count", count, 3'd1);
        chk("t4_pend", pending, 32'h4);
        chk("t4_wa", rf_wa, 5'd2);
        idle(5'd0);
        // Push two while one drains at count 2
        cyc(1, 5'd6, 32'h6, 1, 5'd7, 32'h7, 5'd6);
        cyc(1, 5'd8, 32'h8, 1, 5'd9, 32'h9, 5'd8);
        chk("t6_count3", count, 3'd3);
        chk("t6_ready0", wb_ready, 1'b0);
        idle(5'd9);
        chk("t6_ready1", wb_ready, 1'b1);
        cyc(1, 5'd10, 32'hA, 1, 5'd11, 32'hB, 5'd0);
        // Asynchronous reset with three entries queued
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("rst_count", count, 3'd0);
        chk("rst_we", rf_we, 1'b0);
        chk("rst_pend", pending, 32'd0);
        check_model("rst_async");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Streaming x5..x12 across pointer wrap
        dlog.delete();
        i = 0;
        n = 0;
        while (i < 4 && n < 40) begin
            cyc(1, 5'(5 + 2 * i), 32'(500 + i), 1, 5'(6 + 2 * i), 32'(600 + i), 5'(5 + i));
            if (took) i++;
            n++;
        end
        chk("stream_fill", i, 4);
        n = 0;
        while (q.size() != 0 && n < 20) begin
            idle(5'd0);
            n++;
        end
        chk("stream_drain", count, 3'd0);
        chk("stream_len", dlog.size(), 8);
        foreach (dlog[k]) chk("stream_order", dlog[k], 5 + k);
        // Random traffic
        for (int r = 0; r < 400; r++) begin
            cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                5'($urandom_range(0, 7)));
        end
        for (int r = 0; r < 6; r++) idle(5'($urandom_range(0, 7)));
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
